// File: rtl/uart_serdes_pkg.sv
// uart_serdes_pkg: shared FSM encodings and frame constants for the UART serdes
package uart_serdes_pkg;
   localparam int DATA_BITS = 8;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHI} rx_state_t;
endpackage

// File: rtl/uart_serdes_rx.sv
// uart_rx: oversampled 8N1 receiver with 2-flop synchronizer, mid-bit sampling and framing check
module uart_rx
   import uart_serdes_pkg::*;
#(
   parameter int OS = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bitxce,
   input  logic       rxpin,
   output logic [7:0] q,
   output logic       bytercvd,
   output logic       frame_err
);
   localparam logic [4:0] LAST = 5'(OS - 1);
   localparam logic [4:0] MID = 5'(OS / 2 - 1);
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
   rx_state_t state, state_n;
   logic s1, s2;
   logic [4:0] cnt, cnt_n;
   logic [2:0] bitn, bitn_n;
   logic [7:0] sh, sh_n, q_n;
   logic good_n, ferr_n;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1        <= 1'b1;
         s2        <= 1'b1;
         state     <= RX_IDLE;
         cnt       <= '0;
         bitn      <= '0;
         sh        <= '0;
         q         <= '0;
         bytercvd  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         s1        <= rxpin;
         s2        <= s1;
         state     <= state_n;
         cnt       <= cnt_n;
         bitn      <= bitn_n;
         sh        <= sh_n;
         q         <= q_n;
         bytercvd  <= good_n;
         frame_err <= ferr_n;
      end
   // q and its strobe are registered together so q is already stable while bytercvd is high
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      bitn_n  = bitn;
      sh_n    = sh;
      q_n     = q;
      good_n  = 1'b0;
      ferr_n  = 1'b0;
      if (bitxce)
         case (state)
            RX_IDLE:
               if (!s2) begin
                  state_n = RX_START;
                  cnt_n   = '0;
               end
            RX_START:
               if (cnt == MID) begin
                  state_n = s2 ? RX_IDLE : RX_DATA;
                  cnt_n   = '0;
                  bitn_n  = '0;
               end else cnt_n = cnt + 5'd1;
            RX_DATA:
               if (cnt == LAST) begin
                  cnt_n   = '0;
                  sh_n    = {s2, sh[7:1]};
                  bitn_n  = bitn + 3'd1;
                  state_n = (bitn == LAST_BIT) ? RX_STOP : RX_DATA;
               end else cnt_n = cnt + 5'd1;
            RX_STOP:
               if (cnt == LAST) begin
                  cnt_n   = '0;
                  good_n  = s2;
                  ferr_n  = !s2;
                  q_n     = s2 ? sh : q;
                  state_n = s2 ? RX_IDLE : RX_WAITHI;
               end else cnt_n = cnt + 5'd1;
            RX_WAITHI: state_n = s2 ? RX_IDLE : RX_WAITHI;
            default: state_n = RX_IDLE;
         endcase
   end
endmodule

// File: rtl/uart_serdes.sv
// uart_serdes: oversampled 8N1 transmitter (inline) plus uart_rx receiver, paced by the bitxce strobe
module uart_serdes
   import uart_serdes_pkg::*;
#(
   parameter int OS = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bitxce,
   input  logic       load,
   input  logic [7:0] d,
   output logic       txbusy,
   output logic       txpin,
   input  logic       rxpin,
   output logic [7:0] q,
   output logic       bytercvd,
   output logic       frame_err
);
   localparam logic [4:0] LAST = 5'(OS - 1);
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
   tx_state_t state, state_n;
   logic [7:0] sh, sh_n;
   logic [4:0] cnt, cnt_n;
   logic [2:0] bitn, bitn_n;
   logic txpin_n;
   assign txbusy = state != TX_IDLE;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= TX_IDLE;
         sh    <= '0;
         cnt   <= '0;
         bitn  <= '0;
         txpin <= 1'b1;
      end else begin
         state <= state_n;
         sh    <= sh_n;
         cnt   <= cnt_n;
         bitn  <= bitn_n;
         txpin <= txpin_n;
      end
   // In TX_START a high txpin means the start bit has not been launched yet
   always_comb begin
      state_n = state;
      sh_n    = sh;
      cnt_n   = cnt;
      bitn_n  = bitn;
      txpin_n = txpin;
      case (state)
         TX_IDLE:
            if (load) begin
               sh_n    = d;
               cnt_n   = '0;
               bitn_n  = '0;
               state_n = TX_START;
            end
         TX_START:
            if (bitxce) begin
               if (txpin) txpin_n = 1'b0;
               else if (cnt == LAST) begin
                  cnt_n   = '0;
                  txpin_n = sh[0];
                  sh_n    = sh >> 1;
                  state_n = TX_DATA;
               end else cnt_n = cnt + 5'd1;
            end
         TX_DATA:
            if (bitxce) begin
               if (cnt == LAST) begin
                  cnt_n   = '0;
                  bitn_n  = bitn + 3'd1;
                  txpin_n = (bitn == LAST_BIT) ? 1'b1 : sh[0];
                  sh_n    = sh >> 1;
                  state_n = (bitn == LAST_BIT) ? TX_STOP : TX_DATA;
               end else cnt_n = cnt + 5'd1;
            end
         TX_STOP:
            if (bitxce) begin
               cnt_n   = (cnt == LAST) ? 5'd0 : cnt + 5'd1;
               state_n = (cnt == LAST) ? TX_IDLE : TX_STOP;
            end
      endcase
   end
   uart_rx #(.OS(OS)) u_rx (
      .clk(clk),
      .rst(rst),
      .bitxce(bitxce),
      .rxpin(rxpin),
      .q(q),
      .bytercvd(bytercvd),
      .frame_err(frame_err)
   );
endmodule

// File: tb/tb_uart_serdes.sv
// tb_uart_serdes: table-driven and randomized checks of uart_serdes at OS=8 and OS=16 (bitxce every 13 clk)
module tb_uart_serdes;
   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         hold;
      logic       glitch;
      int         exp_rcvd;
      int         exp_ferr;
      logic [7:0] exp_q;
   } rx_vec_t;
   typedef struct {
      logic [7:0] data;
      logic [9:0] bits;
      logic       extra;
   } tx_vec_t;
   logic clk = 0, rst = 1, bitxce = 0;
   logic load = 0, load16 = 0, loop = 0, rx_drv = 1;
   logic [7:0] d = 0, d16 = 0;
   logic txbusy, txpin, bytercvd, frame_err, rxpin;
   logic txbusy16, txpin16, bytercvd16, frame_err16;
   logic [7:0] q, q16;
   int n_checks = 0, n_fail = 0;
   int cyc = 0, xcnt = 0;
   int n_rcvd = 0, n_ferr = 0, n_both = 0, n_qchg = 0, last_rcvd_cyc = 0, busy_fall = 0;
   int n_rcvd16 = 0, n_ferr16 = 0;
   logic [7:0] rlog[0:1023];
   logic [7:0] rlog16[0:1023];
   logic [7:0] q_prev = 0;
   logic busy_prev = 0;
   rx_vec_t rxv[4];
   tx_vec_t txv[2];
   assign rxpin = loop ? txpin : rx_drv;
   uart_serdes #(.OS(8)) dut (
      .clk(clk), .rst(rst), .bitxce(bitxce), .load(load), .d(d), .txbusy(txbusy), .txpin(txpin),
      .rxpin(rxpin), .q(q), .bytercvd(bytercvd), .frame_err(frame_err));
   uart_serdes #(.OS(16)) dut16 (
      .clk(clk), .rst(rst), .bitxce(bitxce), .load(load16), .d(d16), .txbusy(txbusy16), .txpin(txpin16),
      .rxpin(txpin16), .q(q16), .bytercvd(bytercvd16), .frame_err(frame_err16));
   always #5 clk = ~clk;
   always @(negedge clk) begin
      cyc = cyc + 1;
      xcnt = (xcnt == 12) ? 0 : xcnt + 1;
      bitxce = (xcnt == 0);
   end
   always @(negedge clk) begin
      if (bytercvd) begin
         if (n_rcvd < 1024) rlog[n_rcvd] = q;
         n_rcvd = n_rcvd + 1;
         last_rcvd_cyc = cyc;
      end
      if (frame_err) n_ferr = n_ferr + 1;
      if (bytercvd && frame_err) n_both = n_both + 1;
      if (q != q_prev && !bytercvd) n_qchg = n_qchg + 1;
      q_prev = q;
      if (busy_prev && !txbusy) busy_fall = cyc;
      busy_prev = txbusy;
      if (bytercvd16) begin
         if (n_rcvd16 < 1024) rlog16[n_rcvd16] = q16;
         n_rcvd16 = n_rcvd16 + 1;
      end
      if (frame_err16) n_ferr16 = n_ferr16 + 1;
   end
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask
   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask
   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic send_rx(input logic [7:0] b, input logic stop, input int bt, input int hold_bits);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx_drv = f[i];
         clks(bt);
      end
      if (!stop) clks(hold_bits * bt);
      rx_drv = 1;
   endtask
   task automatic tx_frame(input logic [7:0] b, input logic [9:0] bits, input logic extra);
      int n, t_load;
      d = b;
      load = 1;
      t_load = cyc;
      clks(1);
      load = 0;
      chk($sformatf("txbusy_after_load_%02h", b), txbusy, 1);
      chk($sformatf("txpin_before_tick_%02h", b), txpin, 1);
      n = 0;
      while (txpin && n < 40) begin
         clks(1);
         n++;
      end
      chk_range($sformatf("tx_start_delay_%02h", b), n, 0, 14);
      clks(52);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("tx_bit%0d_%02h", i, b), txpin, bits[i]);
         if (extra && i == 4) begin
            d = 8'hFF;
            load = 1;
            clks(1);
            load = 0;
            clks(103);
         end else clks(104);
      end
      chk_range($sformatf("tx_busy_len_%02h", b), busy_fall - t_load, 1040, 1056);
      clks(200);
      chk($sformatf("tx_idle_after_%02h", b), {txbusy, txpin}, 1);
   endtask
   task automatic loopback(input bit sel, input logic [7:0] b);
      int n;
      n = 0;
      if (sel) begin
         d16 = b;
         load16 = 1;
      end else begin
         d = b;
         load = 1;
      end
      clks(1);
      load = 0;
      load16 = 0;
      while ((sel ? txbusy16 : txbusy) && n < 2400) begin
         clks(1);
         n++;
      end
      chk(sel ? "lb16_busy_fall" : "lb8_busy_fall", int'(n < 2400), 1);
   endtask
   initial begin
      int r0, f0, t0, n, bt, base;
      logic [7:0] b;
      logic [7:0] exp_q[$];
      rxv[0] = '{8'h3C, 1'b1, 0, 1'b0, 1, 0, 8'h3C};
      rxv[1] = '{8'h81, 1'b1, 0, 1'b1, 1, 0, 8'h81};
      rxv[2] = '{8'h55, 1'b0, 20, 1'b0, 0, 1, 8'h81};
      rxv[3] = '{8'hC3, 1'b1, 0, 1'b0, 1, 0, 8'hC3};
      txv[0] = '{8'hA5, 10'b1101001010, 1'b1};
      txv[1] = '{8'h0F, 10'b1000011110, 1'b0};
      clks(3);
      chk("rst_txpin", txpin, 1);
      chk("rst_txbusy", txbusy, 0);
      chk("rst_q", q, 0);
      chk("rst_bytercvd", bytercvd, 0);
      chk("rst_frame_err", frame_err, 0);
      rst = 0;
      clks(5);
      d = 8'h5A;
      load = 1;
      clks(1);
      load = 0;
      n = 0;
      while (txpin && n < 40) begin
         clks(1);
         n++;
      end
      clks(30);
      chk("pre_reset_txpin", txpin, 0);
      #3 rst = 1;
      #1;
      chk("async_rst_txpin", txpin, 1);
      chk("async_rst_txbusy", txbusy, 0);
      chk("async_rst_bytercvd", bytercvd, 0);
      clks(3);
      rst = 0;
      n = 0;
      for (int i = 0; i < 1200; i++) begin
         clks(1);
         if (!txpin || txbusy) n++;
      end
      chk("post_reset_line_idle", n, 0);
      chk("post_reset_no_rcvd", n_rcvd + n_ferr, 0);
      for (int i = 0; i < 2; i++) tx_frame(txv[i].data, txv[i].bits, txv[i].extra);
      for (int i = 0; i < 4; i++) begin
         if (rxv[i].glitch) begin
            r0 = n_rcvd;
            f0 = n_ferr;
            rx_drv = 0;
            clks(26);
            rx_drv = 1;
            clks(1300);
            chk("glitch_no_strobe", (n_rcvd - r0) + (n_ferr - f0), 0);
         end
         r0 = n_rcvd;
         f0 = n_ferr;
         t0 = cyc;
         send_rx(rxv[i].data, rxv[i].stop, 104, rxv[i].hold);
         clks(312);
         chk($sformatf("rx_rcvd_%02h", rxv[i].data), n_rcvd - r0, rxv[i].exp_rcvd);
         chk($sformatf("rx_ferr_%02h", rxv[i].data), n_ferr - f0, rxv[i].exp_ferr);
         chk($sformatf("rx_q_%02h", rxv[i].data), q, rxv[i].exp_q);
         if (rxv[i].exp_rcvd == 1) chk_range($sformatf("rx_latency_%02h", rxv[i].data), last_rcvd_cyc - t0, 986, 1008);
      end
      r0 = n_rcvd;
      f0 = n_ferr;
      exp_q = {};
      for (int i = 0; i < 12; i++) begin
         b = 8'($urandom);
         bt = $urandom_range(101, 107);
         exp_q.push_back(b);
         send_rx(b, 1'b1, bt, 0);
         clks($urandom_range(0, 60));
      end
      clks(400);
      chk("rand_rx_count", n_rcvd - r0, 12);
      chk("rand_rx_ferr", n_ferr - f0, 0);
      for (int k = 0; k < 12; k++) chk($sformatf("rand_rx_byte%0d", k), rlog[r0 + k], exp_q[k]);
      for (int s = 0; s < 2; s++) begin
         exp_q = {8'h00, 8'hFF, 8'h96, 8'($urandom), 8'($urandom), 8'($urandom)};
         base = s ? n_rcvd16 : n_rcvd;
         f0 = s ? n_ferr16 : n_ferr;
         loop = 1;
         for (int k = 0; k < 6; k++) loopback(s[0], exp_q[k]);
         clks(s ? 800 : 400);
         chk(s ? "lb16_count" : "lb8_count", (s ? n_rcvd16 : n_rcvd) - base, 6);
         chk(s ? "lb16_ferr" : "lb8_ferr", (s ? n_ferr16 : n_ferr) - f0, 0);
         for (int k = 0; k < 6; k++)
            chk($sformatf("lb%0d_byte%0d", s ? 16 : 8, k), s ? rlog16[base + k] : rlog[base + k], exp_q[k]);
      end
      chk("strobe_overlap", n_both, 0);
      chk("q_change_without_strobe", n_qchg, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
